// File: rtl/matrix_mac_accum.sv
// matrix_mac_accum: sequences entry_out 0..7 and accumulates the 2x2 product C = A x B from streamed elements
module matrix_mac_accum #(
  parameter int ELEM_W = 3,
  parameter int SEL_W = 4,
  localparam int RES_W = 2*ELEM_W+1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [ELEM_W-1:0] element_a,
  input  logic [ELEM_W-1:0] element_b,
  output logic [SEL_W-1:0] entry_out,
  output logic busy,
  output logic done,
  output logic [4*RES_W-1:0] result
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
  state_t state;
  logic [2*ELEM_W-1:0] prod, acc;
  logic [2:0] sample_idx;
  logic sample_valid;
  // The selectors settle on the negedge after entry_out changes, so the step
  // consumed at a posedge is the one entry_out names at that edge.
  assign sample_idx = entry_out[2:0];
  assign sample_valid = entry_out < SEL_W'(8);
  assign prod = element_a * element_b;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      entry_out <= SEL_W'(8);
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      acc <= '0;
    end else begin
      if (sample_valid) begin
        if (sample_idx[0])
          result[sample_idx[2:1]*RES_W +: RES_W] <= RES_W'(acc) + RES_W'(prod);
        else
          acc <= prod;
      end
      case (state)
        IDLE: if (start) begin
          entry_out <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          entry_out <= entry_out + SEL_W'(1);
          if (entry_out == SEL_W'(7)) state <= DRAIN;
        end
        DRAIN: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= FINISH;
        end
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
